agc_mem_sequencer: RTL

- Memory-cycle sequencer between the control unit and the erasable/fixed data memory.
- Accepts one read or write request at a time and drives the memory's address, write data, write enable and timing pulse.
- Latches the memory output into an internal G (buffer) register.
- Emulates core-memory read/restore: every erasable read is followed by a write-back.
- Enforces the protection rules: no writes to fixed memory, no writes to the zero register.

---
 rtl/agc_mem_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/agc_mem_sequencer.sv
// agc_mem_sequencer: memory-cycle sequencer between the control unit and the
// erasable/fixed data memory. Runs one read or write per request, latches the
// memory output into the G register, rewrites erasable reads (core-memory
// restore) and refuses writes to fixed memory and to the zero register.
module agc_mem_sequencer #(
    parameter logic [11:0] ZERO_ADDR  = 12'd7,
    parameter int          TP_WIDTH   = 1,
    parameter bit          RESTORE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wr,
    input  logic [11:0] addr_in,
    input  logic [14:0] wdata,
    output logic        ack,
    output logic [14:0] rdata,
    output logic        err_fixed,
    output logic        busy,
    output logic [11:0] mem_addr,
    output logic [14:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_tp,
    input  logic [14:0] mem_rdata
);

    localparam int          DATA_W  = 15;
    localparam logic [3:0]  TP_LOAD = 4'(TP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SAMPLE,
        S_STROBE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [11:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   g_q, g_d;
    logic                wr_q, wr_d;
    logic                eras_q, eras_d;
    logic                zero_q, zero_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                tp_q, tp_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                strobe;

    function automatic logic is_erasable(input logic [11:0] a);
        return (a[11:10] == 2'b00);
    endfunction

    function automatic logic is_zero(input logic [11:0] a);
        return (a == ZERO_ADDR);
    endfunction

    // State and datapath registers; reset aborts any cycle in progress at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            g_q     <= '0;
            wr_q    <= 1'b0;
            eras_q  <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            tp_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            g_q     <= g_d;
            wr_q    <= wr_d;
            eras_q  <= eras_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            tp_q    <= tp_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: sequences SETUP, SAMPLE, STROBE, RELEASE, DONE per request.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        g_d     = g_q;
        wr_d    = wr_q;
        eras_d  = eras_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        tp_d    = tp_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        strobe  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr_in;
                    wr_d    = wr;
                    wdata_d = wdata;
                    eras_d  = is_erasable(addr_in);
                    zero_d  = is_zero(addr_in);
                    we_d    = 1'b0;
                    tp_d    = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                g_d   = zero_q ? '0 : mem_rdata;
                cnt_d = TP_LOAD;
                if (eras_q && !zero_q) begin
                    if (wr_q) begin
                        strobe = 1'b1;
                    end else if (RESTORE_EN) begin
                        // Restore rewrites exactly what the destructive read returned.
                        wdata_d = mem_rdata;
                        strobe  = 1'b1;
                    end
                end
                we_d    = strobe;
                tp_d    = strobe;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                // Counter runs even when no pulse is issued so timing is uniform.
                if (cnt_q == 4'd0) begin
                    tp_d    = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RELEASE: begin
                // Write enable outlives the timing pulse by this one cycle.
                we_d    = 1'b0;
                ack_d   = 1'b1;
                err_d   = wr_q & ~eras_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign ack       = ack_q;
    assign err_fixed = err_q;
    assign rdata     = g_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_tp    = tp_q;

endmodule
